// File: rtl/im2_int_ctrl.sv
// -----------------------------------------------------------------------------
// im2_int_ctrl
//
// Z80 interrupt-mode-2 responder for the tv80s bus. Latches rising edges on
// up to NUM_SRC request lines, arbitrates them by fixed priority with nesting
// (index 0 highest), drives a registered int_n, answers the interrupt
// acknowledge cycle with a vector byte and retires the in-service source when
// it sees the CPU fetch RETI (ED 4D).
//
// Build option:
//   STATUS_READ_EN - when defined, I/O reads of CTRL_PORT return
//                    {in_service, pending} and reads of VEC_PORT return
//                    vec_base. When undefined, I/O reads are ignored.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   irq_req     request lines, synchronous to clk, rising-edge sensitive
//   m1_n        CPU M1
//   mreq_n      CPU MREQ
//   iorq_n      CPU IORQ
//   rd_n        CPU RD
//   wr_n        CPU WR
//   A           CPU address low byte
//   cpu_do      CPU data out (I/O writes)
//   bus_di      byte presented to CPU di (opcode snoop)
//   dout        data driven to the CPU during acknowledge / read
//   dout_en     dout valid; system muxes dout onto CPU di
//   int_n       interrupt request to CPU, active low, registered
//   in_service  in-service bits
//
// RETI snoop FSM:
//   state        | meaning
//   SNOOP_IDLE   | last committed opcode was not ED
//   SNOOP_GOT_ED | last committed opcode was ED; a 4D now completes RETI
// -----------------------------------------------------------------------------
module im2_int_ctrl #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] CTRL_PORT = 8'h20,
  parameter logic [7:0] VEC_PORT  = 8'h21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               m1_n,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         A,
  input  logic [7:0]         cpu_do,
  input  logic [7:0]         bus_di,
  output logic [7:0]         dout,
  output logic               dout_en,
  output logic               int_n,
  output logic [NUM_SRC-1:0] in_service
);

  localparam int IDXW = $clog2(NUM_SRC);

  localparam logic [7:0] OP_ED   = 8'hED;
  localparam logic [7:0] OP_RETI = 8'h4D;

  typedef enum logic {
    SNOOP_IDLE,
    SNOOP_GOT_ED
  } snoop_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] irq_prev;
  logic [7:0]         vec_base;
  logic               inta_q;
  logic [IDXW-1:0]    ack_idx;
  logic               ack_valid;
  logic               fetch_q;
  logic [7:0]         op_q;
  snoop_state_t       snoop_state;
  snoop_state_t       snoop_next;

  // ---------------------------------------------------------------------------
  // Bus cycle decode
  // ---------------------------------------------------------------------------
  logic inta;
  logic inta_start;
  logic inta_end;
  logic io_wr;
  logic fetch;
  logic op_commit;

  assign inta       = !m1_n && !iorq_n;
  assign inta_start = inta && !inta_q;
  assign inta_end   = inta_q && !inta;
  assign io_wr      = !iorq_n && !wr_n && m1_n;
  assign fetch      = !m1_n && !mreq_n && !rd_n;
  // The opcode byte is only trusted once the fetch has completed.
  assign op_commit  = fetch_q && !fetch;

  // ---------------------------------------------------------------------------
  // Arbitration: any in-service source at or above a request's priority
  // blocks it, which gives nesting with fixed priority.
  // ---------------------------------------------------------------------------
  logic            win_valid;
  logic [IDXW-1:0] win_idx;
  logic            blocked;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    blocked   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      blocked = blocked | in_service[i];
      if (!blocked && !win_valid && pending[i] && mask[i]) begin
        win_valid = 1'b1;
        win_idx   = IDXW'(i);
      end
    end
  end

  // Lowest set in-service bit is the one a RETI retires (the innermost,
  // highest-priority handler).
  logic [NUM_SRC-1:0] is_lowest;
  logic               is_found;

  always_comb begin
    is_lowest = '0;
    is_found  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_service[i] && !is_found) begin
        is_lowest[i] = 1'b1;
        is_found     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / in-service update
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] irq_rise;
  logic [NUM_SRC-1:0] ack_onehot;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] reti_clr;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] in_service_nxt;
  logic               reti_hit;

  assign irq_rise       = irq_req & ~irq_prev;
  assign ack_onehot     = NUM_SRC'(1) << ack_idx;
  // A spurious acknowledge (no winner at INTA start) changes nothing.
  assign ack_clr        = (inta_end && ack_valid) ? ack_onehot : '0;
  assign reti_clr       = reti_hit ? is_lowest : '0;
  // A fresh edge on the acknowledged source in the same cycle must not be lost.
  assign pending_nxt    = (pending & ~ack_clr) | irq_rise;
  assign in_service_nxt = (in_service & ~reti_clr) | ack_clr;

  // ---------------------------------------------------------------------------
  // Data returned to the CPU
  // ---------------------------------------------------------------------------
  logic [7:0] vec_word;
  logic [7:0] dout_nxt;
  logic       dout_en_nxt;

  // win_idx is zero when there is no winner, so the spurious vector falls out
  // of the same expression.
  assign vec_word = {vec_base[7:IDXW+1], win_idx, 1'b0};

`ifdef STATUS_READ_EN
  logic       io_rd;
  logic       rd_hit;
  logic [7:0] status_word;

  assign io_rd       = !iorq_n && !rd_n && m1_n;
  assign rd_hit      = io_rd && ((A == CTRL_PORT) || (A == VEC_PORT));
  assign status_word = 8'({in_service, pending});
`else
  // Low vector-base bits are replaced by the index when the vector is formed.
  logic unused_vec_bits;
  assign unused_vec_bits = ^vec_base[IDXW:0];
`endif

  always_comb begin
    dout_nxt    = dout;
    dout_en_nxt = inta;
    if (inta_start) begin
      dout_nxt = vec_word;
    end
`ifdef STATUS_READ_EN
    if (rd_hit) begin
      dout_en_nxt = 1'b1;
      dout_nxt    = (A == CTRL_PORT) ? status_word : vec_base;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Register file, request and acknowledge state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      in_service <= '0;
      mask       <= '1;
      vec_base   <= 8'h00;
      irq_prev   <= '0;
      inta_q     <= 1'b0;
      ack_idx    <= '0;
      ack_valid  <= 1'b0;
      int_n      <= 1'b1;
      dout       <= 8'h00;
      dout_en    <= 1'b0;
      fetch_q    <= 1'b0;
      op_q       <= 8'h00;
    end else begin
      irq_prev   <= irq_req;
      pending    <= pending_nxt;
      in_service <= in_service_nxt;
      inta_q     <= inta;
      int_n      <= !win_valid;
      dout       <= dout_nxt;
      dout_en    <= dout_en_nxt;
      fetch_q    <= fetch;

      if (inta_start) begin
        ack_idx   <= win_idx;
        ack_valid <= win_valid;
      end

      if (io_wr && (A == CTRL_PORT)) begin
        mask <= cpu_do[NUM_SRC-1:0];
      end
      if (io_wr && (A == VEC_PORT)) begin
        vec_base <= cpu_do;
      end

      if (fetch) begin
        op_q <= bus_di;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RETI snoop FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snoop_state <= SNOOP_IDLE;
    end else begin
      snoop_state <= snoop_next;
    end
  end

  always_comb begin
    snoop_next = snoop_state;
    reti_hit   = 1'b0;
    if (op_commit) begin
      case (snoop_state)
        SNOOP_IDLE: begin
          if (op_q == OP_ED) begin
            snoop_next = SNOOP_GOT_ED;
          end
        end
        SNOOP_GOT_ED: begin
          if (op_q == OP_RETI) begin
            reti_hit   = 1'b1;
            snoop_next = SNOOP_IDLE;
          end else if (op_q == OP_ED) begin
            snoop_next = SNOOP_GOT_ED;
          end else begin
            snoop_next = SNOOP_IDLE;
          end
        end
        default: snoop_next = SNOOP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im2_int_ctrl.sv
`timescale 1ns/1ps
module tb_im2_int_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_req;
  logic         m1_n, mreq_n, iorq_n, rd_n, wr_n;
  logic [7:0]   A, cpu_do, bus_di;
  logic [7:0]   dout;
  logic         dout_en;
  logic         int_n;
  logic [N-1:0] in_service;

  im2_int_ctrl #(.NUM_SRC(N), .CTRL_PORT(8'h20), .VEC_PORT(8'h21)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_req    (irq_req),
    .m1_n       (m1_n),
    .mreq_n     (mreq_n),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .A          (A),
    .cpu_do     (cpu_do),
    .bus_di     (bus_di),
    .dout       (dout),
    .dout_en    (dout_en),
    .int_n      (int_n),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: sets of pending / in-service sources, register values,
  // and the last committed opcode (RETI = ED immediately followed by 4D).
  bit         m_pend[N];
  bit         m_is[N];
  logic [3:0] m_mask;
  logic [7:0] m_vec;
  logic [7:0] m_last_op;
  int         m_ack;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_is[i] = 0; end
    m_mask = 4'hF; m_vec = 8'h00; m_last_op = 8'h00; m_ack = -1;
  endfunction

  // Highest-priority request not shadowed by a handler of equal or higher priority.
  function automatic int model_winner();
    for (int i = 0; i < N; i++) begin
      if (m_is[i]) return -1;
      if (m_pend[i] && m_mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_vector(int idx);
    int k;
    k = (idx < 0) ? 0 : idx;
    return (m_vec & 8'hF8) | 8'(k * 2);
  endfunction

  function automatic logic [N-1:0] model_is_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_is[i];
    return v;
  endfunction

  function automatic logic [N-1:0] model_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic bus_idle();
    m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1;
    A = 8'h00; cpu_do = 8'h00; bus_di = 8'h00;
  endtask

  task automatic apply_reset(int cycles);
    reset = 1; irq_req = '0; bus_idle();
    repeat (cycles) tick();
    reset = 0;
    tick();
    model_reset();
  endtask

  task automatic pulse_irq(logic [N-1:0] bits);
    irq_req = bits; tick();
    irq_req = '0;   tick();
    for (int i = 0; i < N; i++) if (bits[i]) m_pend[i] = 1;
  endtask

  task automatic io_write(logic [7:0] addr, logic [7:0] data);
    A = addr; cpu_do = data; iorq_n = 0; wr_n = 0;
    tick(); tick();
    bus_idle(); tick();
    if (addr == 8'h20) m_mask = data[3:0];
    if (addr == 8'h21) m_vec = data;
  endtask

  task automatic fetch(logic [7:0] op);
    m1_n = 0; mreq_n = 0; rd_n = 0; bus_di = op; tick();
    bus_idle(); tick();
    if (m_last_op == 8'hED && op == 8'h4D) begin
      for (int i = 0; i < N; i++) if (m_is[i]) begin m_is[i] = 0; break; end
    end
    m_last_op = op;
  endtask

  task automatic mem_read(logic [7:0] d);
    mreq_n = 0; rd_n = 0; bus_di = d; tick();
    bus_idle(); tick();
  endtask

  task automatic inta_begin();
    m_ack = model_winner();
    m1_n = 0; iorq_n = 0; tick();
  endtask

  task automatic inta_end();
    bus_idle(); tick();
    if (m_ack >= 0) begin m_pend[m_ack] = 0; m_is[m_ack] = 1; end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset(3);
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n: got %b expected 1", int_n); end
    vectors++; if (dout_en !== 1'b0) begin errors++; $display("FAIL reset_dout_en: got %b expected 0", dout_en); end
    vectors++; if (in_service !== 4'h0) begin errors++; $display("FAIL reset_in_service: got %h expected 0", in_service); end
    vectors++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    pulse_irq(4'b1000); settle();
    vectors++; if (int_n !== 1'b0) begin errors++; $display("FAIL reset_mask_all_ones: got %b expected 0", int_n); end
    apply_reset(3);
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL reset_clears_pending: got %b expected 1", int_n); end
  endtask

  task automatic test_basic_ack();
    io_write(8'h21, 8'h40);
    irq_req = 4'b0100; tick();
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL basic_int_n_edge1: got %b expected 1", int_n); end
    irq_req = '0; tick();
    m_pend[2] = 1;
    vectors++; if (int_n !== 1'b0) begin errors++; $display("FAIL basic_int_n_edge2: got %b expected 0", int_n); end
    inta_begin();
    vectors++; if (dout_en !== 1'b1) begin errors++; $display("FAIL basic_dout_en: got %b expected 1", dout_en); end
    vectors++; if (dout !== 8'h44) begin errors++; $display("FAIL basic_vector: got %h expected 44", dout); end
    tick();
    vectors++; if (dout_en !== 1'b1) begin errors++; $display("FAIL basic_dout_en_held: got %b expected 1", dout_en); end
    inta_end();
    vectors++; if (dout_en !== 1'b0) begin errors++; $display("FAIL basic_dout_en_end: got %b expected 0", dout_en); end
    vectors++; if (in_service !== 4'b0100) begin errors++; $display("FAIL basic_in_service: got %b expected 0100", in_service); end
    tick();
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL basic_int_n_after: got %b expected 1", int_n); end
  endtask

  task automatic test_nesting();
    pulse_irq(4'b0001); settle();
    vectors++; if (int_n !== 1'b0) begin errors++; $display("FAIL nest_int_n_src0: got %b expected 0", int_n); end
    inta_begin();
    vectors++; if (dout !== 8'h40) begin errors++; $display("FAIL nest_vector_src0: got %h expected 40", dout); end
    inta_end(); settle();
    vectors++; if (in_service !== 4'b0101) begin errors++; $display("FAIL nest_is_0101: got %b expected 0101", in_service); end
    pulse_irq(4'b1000); settle();
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL nest_src3_blocked: got %b expected 1", int_n); end
    fetch(8'hED); fetch(8'h4D); settle();
    vectors++; if (in_service !== 4'b0100) begin errors++; $display("FAIL nest_reti1_is: got %b expected 0100", in_service); end
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL nest_reti1_int_n: got %b expected 1", int_n); end
    fetch(8'hED); fetch(8'h4D); settle();
    vectors++; if (in_service !== 4'b0000) begin errors++; $display("FAIL nest_reti2_is: got %b expected 0000", in_service); end
    vectors++; if (int_n !== 1'b0) begin errors++; $display("FAIL nest_reti2_int_n: got %b expected 0", int_n); end
    inta_begin();
    vectors++; if (dout !== 8'h46) begin errors++; $display("FAIL nest_vector_src3: got %h expected 46", dout); end
    inta_end();
    fetch(8'hED); fetch(8'h4D); settle();
  endtask

  task automatic test_mask();
    io_write(8'h20, 8'h0E);
    pulse_irq(4'b0001); settle();
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL mask_blocks: got %b expected 1", int_n); end
    io_write(8'h20, 8'h0F);
    vectors++; if (int_n !== 1'b0) begin errors++; $display("FAIL mask_unmask: got %b expected 0", int_n); end
    inta_begin();
    vectors++; if (dout !== 8'h40) begin errors++; $display("FAIL mask_vector: got %h expected 40", dout); end
    inta_end();
    fetch(8'hED); fetch(8'h4D); settle();
    vectors++; if (in_service !== 4'b0000) begin errors++; $display("FAIL mask_cleanup_is: got %b expected 0000", in_service); end
  endtask

  task automatic test_reti_filter();
    pulse_irq(4'b0010); settle();
    inta_begin(); inta_end(); settle();
    vectors++; if (in_service !== 4'b0010) begin errors++; $display("FAIL filt_setup: got %b expected 0010", in_service); end
    fetch(8'hED); fetch(8'h45); settle();
    vectors++; if (in_service !== 4'b0010) begin errors++; $display("FAIL filt_retn: got %b expected 0010", in_service); end
    fetch(8'hED); fetch(8'h5E); settle();
    vectors++; if (in_service !== 4'b0010) begin errors++; $display("FAIL filt_im2: got %b expected 0010", in_service); end
    fetch(8'hED); mem_read(8'h4D); fetch(8'h00); settle();
    vectors++; if (in_service !== 4'b0010) begin errors++; $display("FAIL filt_data_byte: got %b expected 0010", in_service); end
    fetch(8'hED); fetch(8'hED); fetch(8'h4D); settle();
    vectors++; if (in_service !== 4'b0000) begin errors++; $display("FAIL filt_ed_ed_4d: got %b expected 0000", in_service); end
  endtask

  task automatic test_simultaneous();
    pulse_irq(4'b0010); settle();
    inta_begin();
    vectors++; if (dout !== model_vector(1)) begin errors++; $display("FAIL simul_vector: got %h expected %h", dout, model_vector(1)); end
    irq_req = 4'b0010;
    inta_end();
    irq_req = '0; m_pend[1] = 1;
    tick(); settle();
    vectors++; if (in_service !== 4'b0010) begin errors++; $display("FAIL simul_is: got %b expected 0010", in_service); end
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL simul_self_block: got %b expected 1", int_n); end
    fetch(8'hED); fetch(8'h4D); settle();
    vectors++; if (int_n !== 1'b0) begin errors++; $display("FAIL simul_pending_kept: got %b expected 0", int_n); end
    inta_begin(); inta_end();
    fetch(8'hED); fetch(8'h4D); settle();
  endtask

  task automatic test_spurious();
    io_write(8'h21, 8'h5F);
    inta_begin();
    vectors++; if (dout !== 8'h58) begin errors++; $display("FAIL spur_vector: got %h expected 58", dout); end
    vectors++; if (dout_en !== 1'b1) begin errors++; $display("FAIL spur_dout_en: got %b expected 1", dout_en); end
    inta_end(); settle();
    vectors++; if (in_service !== 4'b0000) begin errors++; $display("FAIL spur_no_change: got %b expected 0000", in_service); end
    pulse_irq(4'b1000); settle();
    inta_begin();
    vectors++; if (dout !== 8'h5E) begin errors++; $display("FAIL spur_vec_idx_bits: got %h expected 5E", dout); end
    inta_end();
    fetch(8'hED); fetch(8'h4D); settle();
  endtask

  task automatic test_io_read();
    A = 8'h20; iorq_n = 0; rd_n = 0; tick(); tick();
`ifdef STATUS_READ_EN
    vectors++; if (dout_en !== 1'b1) begin errors++; $display("FAIL read_dout_en: got %b expected 1", dout_en); end
    vectors++; if (dout !== 8'({model_is_vec(), model_pend_vec()})) begin errors++; $display("FAIL read_status: got %h", dout); end
`else
    vectors++; if (dout_en !== 1'b0) begin errors++; $display("FAIL read_ignored: got %b expected 0", dout_en); end
`endif
    bus_idle(); tick();
  endtask

  task automatic test_reset_mid_inta();
    pulse_irq(4'b0100); settle();
    inta_begin();
    vectors++; if (dout_en !== 1'b1) begin errors++; $display("FAIL rmid_dout_en_pre: got %b expected 1", dout_en); end
    #3 reset = 1;
    #1;
    vectors++; if (dout_en !== 1'b0) begin errors++; $display("FAIL rmid_dout_en_async: got %b expected 0", dout_en); end
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL rmid_int_n: got %b expected 1", int_n); end
    vectors++; if (in_service !== 4'b0000) begin errors++; $display("FAIL rmid_is: got %b expected 0000", in_service); end
    bus_idle(); irq_req = '0;
    tick(); tick();
    reset = 0; model_reset(); tick(); settle();
    vectors++; if (int_n !== 1'b1) begin errors++; $display("FAIL rmid_pending_cleared: got %b expected 1", int_n); end
    pulse_irq(4'b1000); settle();
    inta_begin();
    vectors++; if (dout !== 8'h06) begin errors++; $display("FAIL rmid_vec_base_reset: got %h expected 06", dout); end
    inta_end();
    fetch(8'hED); fetch(8'h4D); settle();
  endtask

  task automatic test_random();
    int op;
    logic       exp_int_n;
    logic [7:0] exp_vec;
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: pulse_irq(4'($urandom_range(1, 15)));
        1: io_write(8'h20, 8'($urandom_range(0, 255)));
        2: io_write(8'h21, 8'($urandom_range(0, 255)));
        3: begin
          inta_begin();
          exp_vec = model_vector(m_ack);
          vectors++; if (dout !== exp_vec) begin errors++; $display("FAIL rand_vector it=%0d: got %h expected %h", it, dout, exp_vec); end
          vectors++; if (dout_en !== 1'b1) begin errors++; $display("FAIL rand_dout_en it=%0d: got %b expected 1", it, dout_en); end
          tick();
          inta_end();
        end
        4: begin fetch(8'hED); fetch(8'h4D); end
        default: fetch(($urandom_range(0, 3) == 0) ? 8'hED : 8'($urandom_range(0, 255)));
      endcase
      settle();
      exp_int_n = (model_winner() < 0);
      vectors++; if (int_n !== exp_int_n) begin errors++; $display("FAIL rand_int_n it=%0d op=%0d: got %b expected %b", it, op, int_n, exp_int_n); end
      vectors++; if (in_service !== model_is_vec()) begin errors++; $display("FAIL rand_in_service it=%0d op=%0d: got %b expected %b", it, op, in_service, model_is_vec()); end
      vectors++; if (dout_en !== 1'b0) begin errors++; $display("FAIL rand_dout_en_idle it=%0d: got %b expected 0", it, dout_en); end
    end
  endtask

  initial begin
    reset = 1; irq_req = '0; bus_idle(); model_reset();
    test_reset();
    test_basic_ack();
    test_nesting();
    test_mask();
    test_reti_filter();
    test_simultaneous();
    test_spurious();
    test_io_read();
    test_reset_mid_inta();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
